router_port_sched: RTL and testbench

Clocked round-robin scheduler for one router output port. It shares a single output channel between the four packet sources that can target it. Each source is an input split leg from N/S/E/W/PE, minus the port's own direction. Packets are single-flit, 31-bit words. The block sits between the split stage and the output link, replacing a tree of 2-way arbiters with one fair, registered stage that keeps per-source grant statistics.

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_port_sched_rr_pick.sv | 28 ++
 rtl/router_port_sched.sv | 80 ++++++++
 tb/tb_router_port_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router: packet geometry, port identifiers and the
// header field positions used by the upstream routing stage.
package router_pkg;

  localparam int PKT_WIDTH = 31;
  localparam int NUM_IN    = 4;

  typedef logic [1:0] port_id_t;

  // Header fields, most significant bits of the packet.
  localparam int XSRC_HI = 30;
  localparam int XSRC_LO = 29;
  localparam int YSRC_HI = 28;
  localparam int YSRC_LO = 27;
  localparam int XDST_HI = 26;
  localparam int XDST_LO = 25;
  localparam int YDST_HI = 24;
  localparam int YDST_LO = 23;

  typedef enum logic [1:0] {
    PORT_W = 2'b00,
    PORT_S = 2'b01,
    PORT_P = 2'b10,
    PORT_E = 2'b11
  } port_dir_e;

  function automatic port_id_t next_port(input port_id_t p);
    return port_id_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/router_port_sched_rr_pick.sv
// Rotate-priority encoder: grants the first requester at or above ptr,
// wrapping from 3 back to 0.
module rr_pick
  import router_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt_onehot,
  output logic [1:0] gnt_idx,
  output logic       any
);

  port_id_t cand;

  always_comb begin
    gnt_idx    = '0;
    cand       = '0;
    gnt_onehot = '0;
    any        = |req;
    // Walk from farthest to nearest so the nearest requester wins last.
    for (int k = 3; k >= 0; k--) begin
      cand = port_id_t'(ptr + port_id_t'(k));
      if (req[cand]) gnt_idx = cand;
    end
    if (any) gnt_onehot = 4'b0001 << gnt_idx;
  end

endmodule

// File: rtl/router_port_sched.sv
// Round-robin scheduler sharing one registered output channel between four
// packet sources, with saturating per-source grant counters.
module router_port_sched #(
  parameter int WIDTH  = 31,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [1:0]              out_src,
  input  logic                    out_ready,
  input  logic                    cnt_clr,
  output logic [NUM_IN*CNT_W-1:0] grant_cnt
);
  import router_pkg::*;

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; a source holds valid/data until it sees ready, and the output
  // register holds data/src stable while out_valid is high and out_ready low.

  port_id_t   ptr;
  logic       load;
  logic       accept;
  logic [3:0] gnt_onehot;
  port_id_t   gnt_idx;
  logic       any_req;
  logic [WIDTH-1:0] sel_data;
  logic [CNT_W-1:0] cnt_q [NUM_IN];

  rr_pick u_pick (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  assign load     = !out_valid || out_ready;
  assign accept   = load && any_req && rst_n;
  // Reset gating keeps in_ready low while the block is held in reset.
  assign in_ready = (load && rst_n) ? gnt_onehot : '0;
  assign sel_data = in_data[gnt_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= gnt_idx;
        ptr       <= next_port(gnt_idx);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (cnt_clr) begin
        cnt_q[i] <= '0;
      end else if (accept && gnt_onehot[i] && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_router_port_sched.sv
// Directed bench for router_port_sched: drivers push expected packets into a
// queue, a monitor pops and compares each accepted output.
module tb_router_port_sched;

  localparam int W  = 31;
  localparam int N  = 4;
  localparam int CW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic            cnt_clr;
  logic [N*CW-1:0] grant_cnt;

  logic [W-1:0]    src_data [N];
  logic [W+1:0]    exp_q [$];
  logic [W-1:0]    last_data;
  logic [1:0]      last_src;
  logic [3:0]      cont_exp [8];
  int              n_cmp;
  int              n_bad;

  router_port_sched #(.WIDTH(W), .NUM_IN(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = src_data[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [CW-1:0] cnt(input int i);
    return grant_cnt[i*CW +: CW];
  endfunction

  // One cycle: drive, check in_ready against the hand value, queue the packet
  // that ready implies, then advance past the edge.
  task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] exp_rdy,
                      input logic clr = 1'b0);
    logic [1:0] w;
    in_valid  = v;
    out_ready = rdy;
    cnt_clr   = clr;
    #1;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    w = oh_idx(exp_rdy);
    if (exp_rdy != 4'b0000) begin
      exp_q.push_back({w, src_data[w]});
      last_data = src_data[w];
      last_src  = w;
    end
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    if (exp_rdy != 4'b0000) src_data[w] = src_data[w] + 31'h01010101;
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got src %0d data 0x%0h, queue empty", out_src, out_data);
      end else begin
        check("out_pkt", 64'({out_src, out_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    src_data[0] = 31'h12345678;
    src_data[1] = 31'h2ABC0011;
    src_data[2] = 31'h3DEF0022;
    src_data[3] = 31'h40120033;
    last_data = '0;
    last_src  = '0;
    cont_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b0;
    cnt_clr = 1'b0;

    // reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_grant_cnt", 64'(grant_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single source
    step(4'b0001, 1'b1, 4'b0001);
    check("single_out_valid", 64'(out_valid), 64'd1);
    check("single_cnt0", 64'(cnt(0)), 64'd1);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < N; i++) check("clr_cnt", 64'(cnt(i)), 64'd0);

    // full contention from ptr=1
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, cont_exp[i]);
    for (int i = 0; i < N; i++) check("cont_cnt", 64'(cnt(i)), 64'd2);

    // backpressure on a source-2 packet
    step(4'b0100, 1'b1, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      step(4'b1011, 1'b0, 4'b0000);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", 64'(out_data), 64'(last_data));
      check("bp_out_src", 64'(out_src), 64'd2);
    end
    step(4'b1011, 1'b1, 4'b1000);

    // pointer wrap then idle load
    step(4'b1001, 1'b1, 4'b0001);
    step(4'b1001, 1'b1, 4'b1000);
    step(4'b0000, 1'b1, 4'b0000);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_out_src", 64'(out_src), 64'd3);
    check("idle_out_data", 64'(out_data), 64'(last_data));

    // saturation and clear on source 1
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 254; i++) step(4'b0010, 1'b1, 4'b0010);
    check("sat_cnt1_fe", 64'(cnt(1)), 64'hFE);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 1'b1, 4'b0010);
      check("sat_cnt1_ff", 64'(cnt(1)), 64'hFF);
    end
    check("sat_cnt0", 64'(cnt(0)), 64'd0);
    step(4'b0010, 1'b1, 4'b0010, 1'b1);
    check("clr_vs_inc", 64'(cnt(1)), 64'd0);

    // async reset while a packet is held
    step(4'b0010, 1'b1, 4'b0010);
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_grant_cnt", 64'(grant_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 4'b0001);
    check("post_rst_cnt0", 64'(cnt(0)), 64'd1);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
